// File: rtl/tx_filter_ctrl_pkg.sv
// Shared constants for the raised-cosine transmit filter sequencer:
// default geometry, derived widths and the FSM state encoding.
package tx_filter_ctrl_pkg;

    localparam int DEF_OS_FACTOR = 4;
    localparam int DEF_N_COEFFS  = 6;
    localparam int DEF_NB_COEFFS = 8;

    localparam int NB_PHASE = $clog2(DEF_OS_FACTOR);
    localparam int NB_ADDR  = $clog2(DEF_OS_FACTOR * DEF_N_COEFFS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

endpackage

// File: rtl/tx_filter_ctrl_coef_bank_2x.sv
// Two-bank coefficient register file. One bank is active (read by the
// filter), the other is the shadow (written by software). A swap flips the
// bank roles; the packed read of one phase is registered and already looks
// at the post-swap active bank so the output never mixes two sets.
module coef_bank_2x #(
    parameter int OS_FACTOR = 4,
    parameter int N_COEFFS  = 6,
    parameter int NB_COEFFS = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     wr_en,
    input  logic [$clog2(OS_FACTOR*N_COEFFS)-1:0]    wr_addr,
    input  logic [NB_COEFFS-1:0]                     wr_data,
    input  logic                                     swap,
    input  logic [$clog2(OS_FACTOR)-1:0]             rd_phase,
    output logic [N_COEFFS*NB_COEFFS-1:0]            rd_data
);

    localparam int DEPTH = OS_FACTOR * N_COEFFS;
    localparam int AW    = $clog2(DEPTH);

    logic                         bank_sel;
    logic                         sel_next;
    logic [NB_COEFFS-1:0]         mem [2][DEPTH];
    logic [N_COEFFS*NB_COEFFS-1:0] read_word;

    assign sel_next = bank_sel ^ swap;

    // Bank-select flop: names which bank the filter currently reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            bank_sel <= 1'b0;
        end else begin
            bank_sel <= sel_next;
        end
    end

    // Storage: reset clears both banks, writes only ever touch the shadow.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem[b][a] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[~bank_sel][wr_addr] <= wr_data;
        end
    end

    // Gather the taps of the requested phase from the bank that will be active.
    always_comb begin
        read_word = '0;
        for (int k = 0; k < N_COEFFS; k++) begin
            read_word[k*NB_COEFFS +: NB_COEFFS] =
                mem[sel_next][AW'(rd_phase) * AW'(N_COEFFS) + AW'(k)];
        end
    end

    // Registered read so the taps line up with the registered phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= read_word;
        end
    end

endmodule

// File: rtl/tx_filter_ctrl.sv
// Sequencer and coefficient manager for the raised-cosine transmit filter.
// Runs the oversampling phase counter, emits the symbol-rate strobe and
// presents the active polyphase coefficients, swapping banks only at a
// symbol boundary (or immediately when idle).
module tx_filter_ctrl
    import tx_filter_ctrl_pkg::*;
#(
    parameter int OS_FACTOR = DEF_OS_FACTOR,
    parameter int N_COEFFS  = DEF_N_COEFFS,
    parameter int NB_COEFFS = DEF_NB_COEFFS
) (
    input  logic                                   clock,
    input  logic                                   i_reset,
    input  logic                                   i_enable,
    input  logic                                   i_run,
    input  logic                                   i_wr_valid,
    input  logic [$clog2(OS_FACTOR*N_COEFFS)-1:0]  i_wr_addr,
    input  logic [NB_COEFFS-1:0]                   i_wr_data,
    output logic                                   o_wr_ready,
    output logic                                   o_wr_err,
    input  logic                                   i_commit,
    output logic                                   o_commit_pending,
    output logic                                   o_sym_strobe,
    output logic [$clog2(OS_FACTOR)-1:0]           o_phase,
    output logic [N_COEFFS*NB_COEFFS-1:0]          o_coeffs,
    output logic                                   o_running
);

    localparam int NPH   = $clog2(OS_FACTOR);
    localparam int NAD   = $clog2(OS_FACTOR * N_COEFFS);
    localparam int DEPTH = OS_FACTOR * N_COEFFS;
    localparam logic [NPH-1:0] LAST_PHASE = NPH'(OS_FACTOR - 1);

    logic [1:0]     state;
    logic [1:0]     state_next;
    logic [NPH-1:0] phase;
    logic [NPH-1:0] phase_next;
    logic           running;
    logic           advance;
    logic           wrap;
    logic           swap;
    logic           pending;
    logic           sym_strobe;
    logic           wr_err;
    logic           wr_accept;
    logic           addr_ok;

    assign running   = (state != ST_IDLE);
    assign advance   = running & i_enable;
    assign wrap      = advance & (phase == LAST_PHASE);
    assign swap      = pending & i_enable & ((state == ST_IDLE) | wrap);
    assign wr_accept = i_wr_valid & ~pending;
    assign addr_ok   = ({1'b0, i_wr_addr} < (NAD+1)'(DEPTH));
    assign phase_next = advance ? (phase + NPH'(1)) : phase;

    // Next-state logic; everything holds while the global enable is low.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_run & i_enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_enable & ~i_run) begin
                    state_next = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (i_enable) begin
                    if (i_run) begin
                        state_next = ST_RUN;
                    end else if (wrap) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, phase counter and symbol strobe registers.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            phase      <= '0;
            sym_strobe <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            sym_strobe <= wrap;
        end
    end

    // Commit bookkeeping and out-of-range write error pulse.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            pending <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= wr_accept & ~addr_ok;
            if (swap) begin
                pending <= 1'b0;
            end else if (i_commit) begin
                pending <= 1'b1;
            end
        end
    end

    coef_bank_2x #(
        .OS_FACTOR (OS_FACTOR),
        .N_COEFFS  (N_COEFFS),
        .NB_COEFFS (NB_COEFFS)
    ) u_bank (
        .clock    (clock),
        .reset    (i_reset),
        .wr_en    (wr_accept & addr_ok),
        .wr_addr  (i_wr_addr),
        .wr_data  (i_wr_data),
        .swap     (swap),
        .rd_phase (phase_next),
        .rd_data  (o_coeffs)
    );

    assign o_wr_ready       = ~pending;
    assign o_wr_err         = wr_err;
    assign o_commit_pending = pending;
    assign o_sym_strobe     = sym_strobe;
    assign o_phase          = phase;
    assign o_running        = running;

endmodule

// File: tb/tb_tx_filter_ctrl.sv
// Bench for tx_filter_ctrl: directed steps plus a randomized stretch, all
// checked every cycle against a behavioural model built on plain arrays.
module tb_tx_filter_ctrl;
    import tx_filter_ctrl_pkg::*;

    localparam int OS    = DEF_OS_FACTOR;
    localparam int NC    = DEF_N_COEFFS;
    localparam int NB    = DEF_NB_COEFFS;
    localparam int DEPTH = OS * NC;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic                 run = 1'b0;
    logic                 wr_valid = 1'b0;
    logic [NB_ADDR-1:0]   wr_addr = '0;
    logic [NB-1:0]        wr_data = '0;
    logic                 commit = 1'b0;
    logic                 wr_ready;
    logic                 wr_err;
    logic                 commit_pending;
    logic                 sym_strobe;
    logic [NB_PHASE-1:0]  phase;
    logic [NC*NB-1:0]     coeffs;
    logic                 running;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 idle, 1 streaming, 2 draining to boundary.
    int m_active [DEPTH];
    int m_shadow [DEPTH];
    int m_mode;
    int m_phase;
    bit m_pending;
    bit m_strobe;
    bit m_err;

    always #5 clock = ~clock;

    tx_filter_ctrl dut (
        .clock            (clock),
        .i_reset          (reset),
        .i_enable         (enable),
        .i_run            (run),
        .i_wr_valid       (wr_valid),
        .i_wr_addr        (wr_addr),
        .i_wr_data        (wr_data),
        .o_wr_ready       (wr_ready),
        .o_wr_err         (wr_err),
        .i_commit         (commit),
        .o_commit_pending (commit_pending),
        .o_sym_strobe     (sym_strobe),
        .o_phase          (phase),
        .o_coeffs         (coeffs),
        .o_running        (running)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v, input int addr,
                                 input int data, input bit c);
        run      = r;
        enable   = e;
        wr_valid = v;
        wr_addr  = NB_ADDR'(addr);
        wr_data  = NB'(data);
        commit   = c;
    endtask

    task automatic modelStep();
        bit accept;
        bit adv;
        bit wrapped;
        bit do_swap;
        int tmp;
        if (reset) begin
            m_mode = 0; m_phase = 0; m_pending = 0; m_strobe = 0; m_err = 0;
            for (int a = 0; a < DEPTH; a++) begin
                m_active[a] = 0;
                m_shadow[a] = 0;
            end
        end else begin
            accept  = wr_valid && !m_pending;
            m_err   = accept && (int'(wr_addr) >= DEPTH);
            if (accept && int'(wr_addr) < DEPTH) m_shadow[int'(wr_addr)] = int'(wr_data);
            adv     = (m_mode != 0) && enable;
            wrapped = adv && (m_phase == OS - 1);
            do_swap = m_pending && enable && ((m_mode == 0) || wrapped);
            m_strobe = wrapped;
            if (m_mode == 0) begin
                if (run && enable) m_mode = 1;
            end else if (m_mode == 1) begin
                if (enable && !run) m_mode = 2;
            end else if (enable) begin
                if (run) m_mode = 1;
                else if (wrapped) m_mode = 0;
            end
            if (adv) m_phase = (m_phase + 1) % OS;
            if (do_swap) begin
                m_pending = 0;
                for (int a = 0; a < DEPTH; a++) begin
                    tmp = m_active[a];
                    m_active[a] = m_shadow[a];
                    m_shadow[a] = tmp;
                end
            end else if (commit) begin
                m_pending = 1;
            end
        end
    endtask

    task automatic checkAll();
        logic [63:0] exp_c;
        exp_c = '0;
        for (int k = 0; k < NC; k++) exp_c[k*NB +: NB] = NB'(m_active[m_phase*NC + k]);
        checkOutput("phase",   64'(phase),          64'(m_phase));
        checkOutput("strobe",  64'(sym_strobe),     64'(m_strobe));
        checkOutput("coeffs",  64'(coeffs),         exp_c);
        checkOutput("running", 64'(running),        64'(m_mode != 0));
        checkOutput("pending", 64'(commit_pending), 64'(m_pending));
        checkOutput("ready",   64'(wr_ready),       64'(!m_pending));
        checkOutput("wr_err",  64'(wr_err),         64'(m_err));
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic waitPhase(input int p);
        int n;
        n = 0;
        while (int'(phase) != p && n < 4 * OS) begin
            tick();
            n++;
        end
        if (int'(phase) != p) begin
            errors++;
            $error("[TB] FAIL wait_phase got %0d want %0d", phase, p);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (running && n < 4 * OS) begin
            tick();
            n++;
        end
        if (running) begin
            errors++;
            $error("[TB] FAIL wait_idle got %0d want 0", running);
        end
    endtask

    initial begin
        int strobes;
        $display("[TB] start");

        // Reset state.
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("reset_ready", 64'(wr_ready), 64'd1);
        reset = 1'b0;

        // Free run for 20 cycles after the start edge: five strobes expected.
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sym_strobe) strobes++;
        end
        checkOutput("strobe_count", 64'(strobes), 64'd5);
        applyStimulus(0, 1, 0, 0, 0, 0);
        waitIdle();

        // Load the pattern 0x10*phase+tap and commit while idle.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 1, 1, a, (a / NC) * 16 + (a % NC), 0);
            tick();
        end
        applyStimulus(0, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0);
        tick();
        checkOutput("idle_commit_pending", 64'(commit_pending), 64'd0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        waitPhase(2);
        checkOutput("phase2_tap3", 64'(coeffs[3*NB +: NB]), 64'h23);

        // Refill shadow while streaming, then commit mid-symbol.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1, 1, 1, a, int'($urandom_range(0, 255)), 0);
            tick();
        end
        applyStimulus(1, 1, 0, 0, 0, 0);
        waitPhase(1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("ready_blocked", 64'(wr_ready), 64'd0);
        waitPhase(0);
        checkOutput("pending_at_wrap", 64'(commit_pending), 64'd0);

        // Out-of-range writes pulse the error flag and change nothing.
        applyStimulus(1, 1, 1, DEPTH, int'($urandom_range(0, 255)), 0);
        tick();
        checkOutput("err_pulse", 64'(wr_err), 64'd1);
        applyStimulus(1, 1, 1, 31, int'($urandom_range(0, 255)), 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();

        // Stop request mid-symbol drains to the boundary.
        waitPhase(1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        tick();
        waitIdle();
        checkOutput("stop_phase", 64'(phase), 64'd0);

        // Stop then resume before the boundary keeps streaming.
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        waitPhase(1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        checkOutput("resume_running", 64'(running), 64'd1);
        for (int i = 0; i < 6; i++) tick();

        // Enable gap of three cycles at phase 2.
        waitPhase(2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("enable_hold", 64'(phase), 64'd2);
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick();

        // Randomized stretch.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
            tick();
        end

        // Reset at phase 3 with a commit pending and a write presented.
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        waitPhase(0);
        waitPhase(1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0);
        waitPhase(3);
        checkOutput("pending_before_reset", 64'(commit_pending), 64'd1);
        applyStimulus(1, 1, 1, 5, 8'h5a, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_pending", 64'(commit_pending), 64'd0);
        checkOutput("rst_coeffs",  64'(coeffs),         64'd0);
        checkOutput("rst_running", 64'(running),        64'd0);
        checkOutput("rst_phase",   64'(phase),          64'd0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
